// File: rtl/capi_ctxt_track.sv
// Context add/remove/terminate responder with per-context valid bits
// and outstanding-command counters; terminate acks once its context drains.
module capi_ctxt_track #(
   parameter int ctxtid_width = 9,
   parameter int cnt_width    = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_ctxt_add_v,
   input  logic                    i_ctxt_rmv_v,
   input  logic                    i_ctxt_trm_v,
   input  logic [ctxtid_width-1:0] i_ctxt_upd_d,
   output logic                    o_ctxt_add_ack_v,
   output logic                    o_ctxt_rmv_ack_v,
   output logic                    o_ctxt_trm_ack_v,
   input  logic                    i_issue_v,
   input  logic [ctxtid_width-1:0] i_issue_ctxt,
   input  logic                    i_cmpl_v,
   input  logic [ctxtid_width-1:0] i_cmpl_ctxt,
   input  logic                    i_chk_v,
   input  logic [ctxtid_width-1:0] i_chk_ctxt,
   output logic                    o_chk_v,
   output logic                    o_chk_ok,
   output logic                    o_trm_pend,
   output logic                    o_perror
);

   localparam int depth = 2 ** ctxtid_width;

   typedef enum logic {
      IDLE,
      DRAIN
   } state_t;

   state_t state, state_nxt;

   logic [depth-1:0]        valid;
   logic [cnt_width-1:0]    cnt [depth];
   logic [ctxtid_width-1:0] trm_ctxt;

   logic       add_ack_q, rmv_ack_q, chk_v_q, chk_ok_q, perror_q;
   logic [1:0] n_req;
   logic       multi, any_req, idle;
   logic       add_acc, rmv_acc, trm_acc;
   logic       req_err, add_err;
   logic       same, inc_en, dec_en, inc_ovf, dec_unf;
   logic       drained, chk_nxt, err_nxt;

   always_comb begin
      n_req   = {1'b0, i_ctxt_add_v} + {1'b0, i_ctxt_rmv_v}
              + {1'b0, i_ctxt_trm_v};
      any_req = (n_req != 2'd0);
      multi   = (n_req > 2'd1);
      idle    = (state == IDLE);
      add_acc = idle && !multi && i_ctxt_add_v;
      rmv_acc = idle && !multi && i_ctxt_rmv_v;
      trm_acc = idle && !multi && i_ctxt_trm_v;
      req_err = any_req && (!idle || multi);
      add_err = add_acc &&
                (valid[i_ctxt_upd_d] || (cnt[i_ctxt_upd_d] != '0));
      // same-context issue and completion cancel out
      same    = i_issue_v && i_cmpl_v && (i_issue_ctxt == i_cmpl_ctxt);
      inc_en  = i_issue_v && !same;
      dec_en  = i_cmpl_v && !same;
      inc_ovf = inc_en && (&cnt[i_issue_ctxt]);
      dec_unf = dec_en && (cnt[i_cmpl_ctxt] == '0);
      drained = (cnt[trm_ctxt] == '0);
      err_nxt = req_err || add_err || inc_ovf || dec_unf;
      chk_nxt = valid[i_chk_ctxt];
      if (i_chk_ctxt == i_ctxt_upd_d) begin
         if (add_acc)
            chk_nxt = 1'b1;
         else if (rmv_acc || trm_acc)
            chk_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (trm_acc) state_nxt = DRAIN;
         DRAIN:   if (drained) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_trm_pend       = (state == DRAIN);
      o_ctxt_trm_ack_v = (state == DRAIN) && drained;
      o_ctxt_add_ack_v = add_ack_q;
      o_ctxt_rmv_ack_v = rmv_ack_q;
      o_chk_v          = chk_v_q;
      o_chk_ok         = chk_ok_q;
      o_perror         = perror_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         add_ack_q <= 1'b0;
         rmv_ack_q <= 1'b0;
         chk_v_q   <= 1'b0;
         chk_ok_q  <= 1'b0;
         perror_q  <= 1'b0;
         trm_ctxt  <= '0;
         valid     <= '0;
      end else begin
         add_ack_q <= add_acc;
         rmv_ack_q <= rmv_acc;
         chk_v_q   <= i_chk_v;
         chk_ok_q  <= i_chk_v && chk_nxt;
         if (err_nxt)
            perror_q <= 1'b1;
         if (trm_acc)
            trm_ctxt <= i_ctxt_upd_d;
         if (add_acc)
            valid[i_ctxt_upd_d] <= 1'b1;
         else if (rmv_acc || trm_acc)
            valid[i_ctxt_upd_d] <= 1'b0;
      end
   end

   // inc and dec only both fire for different contexts
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < depth; i++)
            cnt[i] <= '0;
      end else begin
         if (inc_en && !inc_ovf)
            cnt[i_issue_ctxt] <= cnt[i_issue_ctxt] + 1'b1;
         if (dec_en && !dec_unf)
            cnt[i_cmpl_ctxt] <= cnt[i_cmpl_ctxt] - 1'b1;
      end
   end

endmodule

// File: tb/tb_capi_ctxt_track.sv
// Scoreboard bench for capi_ctxt_track: stimulus queues expected acks
// and check results; a negedge monitor pops and compares them.
module tb_capi_ctxt_track;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       i_ctxt_add_v, i_ctxt_rmv_v, i_ctxt_trm_v;
   logic [8:0] i_ctxt_upd_d;
   logic       o_ctxt_add_ack_v, o_ctxt_rmv_ack_v, o_ctxt_trm_ack_v;
   logic       i_issue_v, i_cmpl_v, i_chk_v;
   logic [8:0] i_issue_ctxt, i_cmpl_ctxt, i_chk_ctxt;
   logic       o_chk_v, o_chk_ok, o_trm_pend, o_perror;

   capi_ctxt_track #(.ctxtid_width(9), .cnt_width(8)) dut (
      .clk(clk),
      .reset(reset),
      .i_ctxt_add_v(i_ctxt_add_v),
      .i_ctxt_rmv_v(i_ctxt_rmv_v),
      .i_ctxt_trm_v(i_ctxt_trm_v),
      .i_ctxt_upd_d(i_ctxt_upd_d),
      .o_ctxt_add_ack_v(o_ctxt_add_ack_v),
      .o_ctxt_rmv_ack_v(o_ctxt_rmv_ack_v),
      .o_ctxt_trm_ack_v(o_ctxt_trm_ack_v),
      .i_issue_v(i_issue_v),
      .i_issue_ctxt(i_issue_ctxt),
      .i_cmpl_v(i_cmpl_v),
      .i_cmpl_ctxt(i_cmpl_ctxt),
      .i_chk_v(i_chk_v),
      .i_chk_ctxt(i_chk_ctxt),
      .o_chk_v(o_chk_v),
      .o_chk_ok(o_chk_ok),
      .o_trm_pend(o_trm_pend),
      .o_perror(o_perror)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int   c;
      logic ok;
   } chk_t;

   int   add_q[$];
   int   rmv_q[$];
   int   trm_q[$];
   chk_t chk_q[$];
   chk_t ce;

   task automatic cmp(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic unexp(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got pulse expected none (cycle %0d)", nm, cyc);
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (o_ctxt_add_ack_v) begin
            if (add_q.size() == 0) unexp("add_ack");
            else cmp("add_ack_cycle", cyc, add_q.pop_front());
         end
         if (o_ctxt_rmv_ack_v) begin
            if (rmv_q.size() == 0) unexp("rmv_ack");
            else cmp("rmv_ack_cycle", cyc, rmv_q.pop_front());
         end
         if (o_ctxt_trm_ack_v) begin
            if (trm_q.size() == 0) unexp("trm_ack");
            else cmp("trm_ack_cycle", cyc, trm_q.pop_front());
         end
         if (o_chk_v) begin
            if (chk_q.size() == 0) unexp("chk_v");
            else begin
               ce = chk_q.pop_front();
               cmp("chk_cycle", cyc, ce.c);
               cmp("chk_ok", {31'd0, o_chk_ok}, {31'd0, ce.ok});
            end
         end
      end
   end

   task automatic clr();
      i_ctxt_add_v = 1'b0;
      i_ctxt_rmv_v = 1'b0;
      i_ctxt_trm_v = 1'b0;
      i_issue_v    = 1'b0;
      i_cmpl_v     = 1'b0;
      i_chk_v      = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      clr();
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic add(input int c, input bit ack);
      i_ctxt_add_v = 1'b1;
      i_ctxt_upd_d = 9'(c);
      if (ack) add_q.push_back(cyc + 1);
   endtask

   task automatic chk(input int c, input logic ok);
      i_chk_v    = 1'b1;
      i_chk_ctxt = 9'(c);
      chk_q.push_back('{cyc + 1, ok});
   endtask

   int t;

   initial begin
      clr();
      i_ctxt_upd_d = '0;
      i_issue_ctxt = '0;
      i_cmpl_ctxt  = '0;
      i_chk_ctxt   = '0;
      at_neg();
      at_neg();
      cmp("rst_perror", o_perror, 0);
      cmp("rst_pend", o_trm_pend, 0);
      cmp("rst_acks", {o_ctxt_add_ack_v, o_ctxt_rmv_ack_v,
                       o_ctxt_trm_ack_v}, 0);
      cmp("rst_chk_v", o_chk_v, 0);
      step();
      reset = 1'b0;
      step();

      // add / check / remove / check
      add(5, 1); step();
      chk(5, 1'b1); step();
      step();
      i_ctxt_rmv_v = 1'b1; i_ctxt_upd_d = 9'd5;
      rmv_q.push_back(cyc + 1); step();
      chk(5, 1'b0); step();
      add(5, 1); chk(5, 1'b1); step();
      i_ctxt_rmv_v = 1'b1; i_ctxt_upd_d = 9'd5;
      rmv_q.push_back(cyc + 1); step();
      step();
      at_neg(); cmp("perror_clean", o_perror, 0);

      // terminate with empty counter
      add(3, 1); step(); step();
      i_ctxt_trm_v = 1'b1; i_ctxt_upd_d = 9'd3;
      trm_q.push_back(cyc + 1); step();
      at_neg(); cmp("pend_trm3", o_trm_pend, 1);
      step();
      at_neg(); cmp("pend_trm3_done", o_trm_pend, 0);

      // terminate drain, with a protocol-error add mid-drain
      add(7, 1); step();
      repeat (3) begin
         i_issue_v = 1'b1; i_issue_ctxt = 9'd7; step();
      end
      t = cyc;
      i_ctxt_trm_v = 1'b1; i_ctxt_upd_d = 9'd7;
      trm_q.push_back(t + 7);
      chk(7, 1'b0);
      step();
      for (int k = 1; k <= 7; k++) begin
         if (k == 2 || k == 4 || k == 6) begin
            i_cmpl_v = 1'b1; i_cmpl_ctxt = 9'd7;
         end
         if (k == 3) add(1, 0);
         at_neg();
         cmp("pend_drain", o_trm_pend, 1);
         cmp("perror_drain", o_perror, (k >= 4) ? 1 : 0);
         step();
      end
      at_neg(); cmp("pend_drain_done", o_trm_pend, 0);
      do_reset();

      // same-cycle issue+complete nets to zero
      i_issue_v = 1'b1; i_issue_ctxt = 9'd2; step();
      i_issue_v = 1'b1; i_issue_ctxt = 9'd2;
      i_cmpl_v = 1'b1; i_cmpl_ctxt = 9'd2; step();
      at_neg(); cmp("perror_same", o_perror, 0);
      t = cyc;
      i_ctxt_trm_v = 1'b1; i_ctxt_upd_d = 9'd2;
      trm_q.push_back(t + 2); step();
      i_cmpl_v = 1'b1; i_cmpl_ctxt = 9'd2; step();
      step();
      at_neg(); cmp("perror_same_drain", o_perror, 0);

      // underflow
      i_cmpl_v = 1'b1; i_cmpl_ctxt = 9'd9; step();
      at_neg(); cmp("perror_underflow", o_perror, 1);
      i_ctxt_trm_v = 1'b1; i_ctxt_upd_d = 9'd9;
      trm_q.push_back(cyc + 1); step();
      step();
      do_reset();

      // saturation at all-ones
      repeat (255) begin
         i_issue_v = 1'b1; i_issue_ctxt = 9'd8; step();
      end
      at_neg(); cmp("perror_255", o_perror, 0);
      i_issue_v = 1'b1; i_issue_ctxt = 9'd8; step();
      at_neg(); cmp("perror_overflow", o_perror, 1);
      t = cyc;
      i_ctxt_trm_v = 1'b1; i_ctxt_upd_d = 9'd8;
      trm_q.push_back(t + 256); step();
      repeat (255) begin
         i_cmpl_v = 1'b1; i_cmpl_ctxt = 9'd8; step();
      end
      step();
      do_reset();

      // add to an already-valid context: applied, acked, flagged
      add(10, 1); step();
      at_neg(); cmp("perror_add1", o_perror, 0);
      add(10, 1); step();
      at_neg(); cmp("perror_add_twice", o_perror, 1);
      chk(10, 1'b1); step();
      step();
      do_reset();

      // simultaneous add+trm ignored
      add(6, 0);
      i_ctxt_trm_v = 1'b1; step();
      at_neg();
      cmp("perror_multi", o_perror, 1);
      cmp("pend_multi", o_trm_pend, 0);
      chk(6, 1'b0); step();
      step();
      do_reset();

      // reset mid-drain
      repeat (2) begin
         i_issue_v = 1'b1; i_issue_ctxt = 9'd4; step();
      end
      i_ctxt_trm_v = 1'b1; i_ctxt_upd_d = 9'd4; step();
      at_neg(); cmp("pend_pre_rst", o_trm_pend, 1);
      #1 reset = 1'b1;
      #1;
      cmp("pend_async_rst", o_trm_pend, 0);
      cmp("trm_ack_async_rst", o_ctxt_trm_ack_v, 0);
      step();
      step();
      reset = 1'b0;
      step();
      i_ctxt_trm_v = 1'b1; i_ctxt_upd_d = 9'd4;
      trm_q.push_back(cyc + 1); step();
      step();
      at_neg(); cmp("pend_after_rst", o_trm_pend, 0);

      repeat (3) step();
      cmp("add_q_left", add_q.size(), 0);
      cmp("rmv_q_left", rmv_q.size(), 0);
      cmp("trm_q_left", trm_q.size(), 0);
      cmp("chk_q_left", chk_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
